// File: rtl/rbin_stream_source_if.sv
// Hit input and r-bin output stream bundle for rbin_stream_source.
// The master modport is the block itself: it accepts hits and drives the bin stream.
interface rbin_stream_source_if #(
  parameter int R_W            = 12,
  parameter int W_bin_number_a = 8
);
  logic [R_W-1:0]            hit_r;
  logic                      hit_vld;
  logic                      hit_last;
  logic                      hit_ready;
  logic [W_bin_number_a-1:0] r_bin_V_TDATA;
  logic                      r_bin_V_TVALID;
  logic                      r_bin_V_TREADY;

  modport master (
    input  hit_r, hit_vld, hit_last, r_bin_V_TREADY,
    output hit_ready, r_bin_V_TDATA, r_bin_V_TVALID
  );

  modport slave (
    output hit_r, hit_vld, hit_last, r_bin_V_TREADY,
    input  hit_ready, r_bin_V_TDATA, r_bin_V_TVALID
  );
endinterface

// File: rtl/rbin_stream_source.sv
// Converts per-hit r values to r-bin indices and streams them to the LSF histogram,
// sequencing clear sweep / enable / flush. Optional macro RBIN_SAT_EN clamps out-of-range bins.
module rbin_stream_source #(
  parameter int RBINS          = 128,
  parameter int W_bin_number_a = 8,
  parameter int R_W            = 12,
  parameter int R_SHIFT        = 3,
  parameter int FIFO_DEPTH     = 16,
  parameter int FLUSH_CYC      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [R_W-1:0]       r_offset,
  rbin_stream_source_if.master bus,
  output logic                 enable_V,
  output logic                 reset_rbins,
  output logic                 busy,
  output logic                 evt_done,
  output logic [7:0]           n_inrange
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = W_bin_number_a;
  localparam int CW = $clog2(RBINS + FLUSH_CYC + 2);
  localparam logic [CW-1:0] CLR_END   = CW'(RBINS + 1);
  localparam logic [CW-1:0] FLUSH_END = CW'(FLUSH_CYC - 1);
  localparam logic [BW-1:0] OOR_BIN   = {1'b1, {(BW-1){1'b0}}};
  localparam logic [BW-1:0] TOP_BIN   = BW'(RBINS - 1);
  localparam logic [R_W:0]  BIN_LIM   = (R_W+1)'(RBINS);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            last_acc;
  logic [R_W-1:0]  r_off;
  logic [BW:0]     mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full, wr_en, rd_en, rd_last;
  logic [BW-1:0]   rd_bin, wr_bin_p0;

  // Bin index of one hit relative to the latched offset; MSB set means out of range.
  function automatic logic [BW-1:0] to_bin(input logic [R_W-1:0] r, input logic [R_W-1:0] off);
    logic signed [R_W:0] d;
    logic [R_W:0]        q;
    d = $signed({1'b0, r}) - $signed({1'b0, off});
    q = $unsigned(d) >> R_SHIFT;
    if (d[R_W]) begin
`ifdef RBIN_SAT_EN
      to_bin = '0;
`else
      to_bin = OOR_BIN;
`endif
    end else if (q >= BIN_LIM) begin
`ifdef RBIN_SAT_EN
      to_bin = TOP_BIN;
`else
      to_bin = OOR_BIN;
`endif
    end else begin
      to_bin = {1'b0, q[BW-2:0]};
    end
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign bus.hit_ready      = ((state == CLEAR) || (state == STREAM)) && !full && !last_acc;
  assign bus.r_bin_V_TVALID = (state == STREAM) && !empty;
  assign {rd_last, rd_bin}  = mem[rd_ptr[AW-1:0]];
  assign bus.r_bin_V_TDATA  = bus.r_bin_V_TVALID ? rd_bin : '0;

  assign wr_en     = bus.hit_vld && bus.hit_ready;
  assign rd_en     = bus.r_bin_V_TVALID && bus.r_bin_V_TREADY;
  assign wr_bin_p0 = to_bin(bus.hit_r, r_off);

  // Stage p0 -> FIFO storage: bin and last flag captured at write; storage is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {bus.hit_last, wr_bin_p0};
    if ((state == IDLE) && start) r_off <= r_offset;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_acc    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      enable_V    <= 1'b0;
      reset_rbins <= 1'b0;
      busy        <= 1'b0;
      evt_done    <= 1'b0;
      n_inrange   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (bus.hit_last) last_acc <= 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        if (!rd_bin[BW-1]) n_inrange <= sat_inc(n_inrange);
      end
      case (state)
        IDLE: if (start) begin
          state       <= CLEAR;
          cnt         <= '0;
          last_acc    <= 1'b0;
          n_inrange   <= '0;
          reset_rbins <= 1'b1;
          busy        <= 1'b1;
        end
        CLEAR: if (cnt == CLR_END) begin
          state       <= STREAM;
          reset_rbins <= 1'b0;
          enable_V    <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        STREAM: if (rd_en && rd_last) begin
          state <= DRAIN;
          cnt   <= '0;
        end
        DRAIN: if (cnt == FLUSH_END) begin
          state    <= DONE;
          evt_done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          evt_done <= 1'b0;
          enable_V <= 1'b0;
          busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rbin_stream_source.sv
// Self-checking bench for rbin_stream_source: directed scenarios plus randomized events,
// bins predicted by an arithmetic reference model and matched through a scoreboard queue.
`timescale 1ns/1ps
module tb_rbin_stream_source;
  localparam int R_W = 12;
  localparam int BW  = 8;
`ifdef RBIN_SAT_EN
  localparam int T3_NIN = 2;
`else
  localparam int T3_NIN = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start;
  logic [R_W-1:0] r_offset;
  logic           enable_V, reset_rbins, busy, evt_done;
  logic [7:0]     n_inrange;

  rbin_stream_source_if #(.R_W(R_W), .W_bin_number_a(BW)) bus ();

  rbin_stream_source dut (
    .clk(clk), .rst(rst), .start(start), .r_offset(r_offset), .bus(bus),
    .enable_V(enable_V), .reset_rbins(reset_rbins), .busy(busy),
    .evt_done(evt_done), .n_inrange(n_inrange)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int exp_q[$];
  int cur_off, model_nin, evt_cnt, n_acc, e, base, fl;
  int tr_mode = 0;
  bit drained, hold_prev;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: bin width 8 r-units, 128 bins, 128 marks out of range.
  function automatic int model_bin(int r, int off);
    int d, b;
    d = r - off;
    if (d < 0) begin
`ifdef RBIN_SAT_EN
      return 0;
`else
      return 128;
`endif
    end
    b = d / 8;
    if (b >= 128) begin
`ifdef RBIN_SAT_EN
      return 127;
`else
      return 128;
`endif
    end
    return b;
  endfunction

  always @(posedge clk) begin
    #1;
    case (tr_mode)
      0:       bus.r_bin_V_TREADY = 1'b0;
      1:       bus.r_bin_V_TREADY = 1'b1;
      default: bus.r_bin_V_TREADY = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_vld", bus.r_bin_V_TVALID, 1);
        if (exp_q.size() > 0) chk("hold_data", bus.r_bin_V_TDATA, exp_q[0] & 255);
      end
      if (bus.r_bin_V_TVALID) begin
        if (bus.r_bin_V_TREADY) begin
          chk("bin_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("bin", bus.r_bin_V_TDATA, e & 255);
            if ((e & 255) < 128 && model_nin < 255) model_nin++;
            if ((e >> 8) != 0) drained = 1'b1;
          end
        end
        hold_prev = !bus.r_bin_V_TREADY;
      end else begin
        hold_prev = 1'b0;
      end
      if (evt_done) begin
        chk("n_inrange_done", n_inrange, model_nin);
        chk("queue_empty_done", exp_q.size(), 0);
        evt_cnt++;
      end
    end
  end

  task automatic pulse_start(int off);
    start = 1'b1;
    r_offset = R_W'(off);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic begin_event(int off);
    cur_off = off;
    model_nin = 0;
    drained = 1'b0;
    pulse_start(off);
  endtask

  task automatic send_hit(int r, bit last, int gap);
    bit acc = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.hit_r = R_W'(r);
    bus.hit_last = last;
    bus.hit_vld = 1'b1;
    for (int t = 0; t < 1000 && !acc; t++) begin
      @(negedge clk); acc = bus.hit_ready;
      @(posedge clk); #1;
    end
    bus.hit_vld = 1'b0;
    bus.hit_last = 1'b0;
    chk("hit_accepted", int'(acc), 1);
    if (acc) begin
      exp_q.push_back(model_bin(r, cur_off) | (int'(last) << 8));
      n_acc++;
    end
  endtask

  task automatic wait_stream();
    bit ok = 1'b0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      ok = enable_V && !reset_rbins;
    end
    chk("reached_stream", int'(ok), 1);
    @(posedge clk); #1;
  endtask

  task automatic measure_clear();
    int n = 0;
    bit en_bad = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!reset_rbins) break;
      n++;
      if (enable_V) en_bad = 1'b1;
    end
    chk("clear_len", n, 130);
    chk("clear_enable_low", int'(en_bad), 0);
    chk("enable_after_clear", enable_V, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(output int flush);
    bit seen = 1'b0;
    flush = 0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(negedge clk);
      if (evt_done) begin
        seen = 1'b1;
        chk("done_enable", enable_V, 1);
        chk("done_busy", busy, 1);
      end else if (drained && enable_V && !bus.r_bin_V_TVALID) begin
        flush++;
      end
    end
    chk("done_seen", int'(seen), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done_low", evt_done, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n, off;
    start = 1'b0;
    r_offset = '0;
    bus.hit_r = '0;
    bus.hit_vld = 1'b0;
    bus.hit_last = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_enable", enable_V, 0);
    chk("rst_reset_rbins", reset_rbins, 0);
    chk("rst_busy", busy, 0);
    chk("rst_evt_done", evt_done, 0);
    chk("rst_n_inrange", n_inrange, 0);
    chk("rst_hit_ready", bus.hit_ready, 0);
    chk("rst_tvalid", bus.r_bin_V_TVALID, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Clear sweep then a simple in-range event.
    tr_mode = 1;
    begin_event(0);
    measure_clear();
    send_hit(12'h010, 1'b0, 0);
    @(negedge clk);
    chk("latency_tvalid", bus.r_bin_V_TVALID, 1);
    @(posedge clk); #1;
    send_hit(12'h018, 1'b0, 0);
    send_hit(12'h3F8, 1'b1, 0);
    wait_done(fl);
    chk("flush_cycles", fl, 4);
    chk("n_inrange_evt1", n_inrange, 3);

    // Out-of-range hits on both sides.
    begin_event(12'h100);
    wait_stream();
    send_hit(12'h0FF, 1'b0, 0);
    send_hit(12'h500, 1'b1, 0);
    wait_done(fl);
    chk("n_inrange_oor", n_inrange, T3_NIN);

    // Backpressure: 20 hits against a stalled stream.
    tr_mode = 0;
    begin_event(0);
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_hit($urandom_range(0, 4095), i == 19, 0);
      end
      begin
        repeat (150) @(posedge clk);
        #1;
        @(negedge clk);
        chk("full_accepted", n_acc, 16);
        chk("full_hit_ready", bus.hit_ready, 0);
        chk("bp_tvalid", bus.r_bin_V_TVALID, 1);
        repeat (5) @(posedge clk);
        #1;
        tr_mode = 1;
      end
    join
    wait_done(fl);
    chk("bp_total", n_acc, 20);

    // Start during STREAM is ignored; hits after the last are stalled.
    begin_event(12'h040);
    wait_stream();
    send_hit(12'h100, 1'b0, 0);
    send_hit(12'h048, 1'b0, 0);
    pulse_start(12'h200);
    @(negedge clk);
    chk("ign_start_clear", reset_rbins, 0);
    chk("ign_start_enable", enable_V, 1);
    chk("ign_start_busy", busy, 1);
    @(posedge clk); #1;
    send_hit(12'h100, 1'b0, 0);
    send_hit(12'h0C0, 1'b1, 0);
    bus.hit_r = 12'h123;
    bus.hit_last = 1'b1;
    bus.hit_vld = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("late_hit_stall", bus.hit_ready, 0);
      @(posedge clk); #1;
    end
    wait_done(fl);
    chk("late_hit_idle", bus.hit_ready, 0);
    bus.hit_vld = 1'b0;
    bus.hit_last = 1'b0;
    begin_event(12'h100);
    @(negedge clk);
    chk("next_clear_ready", bus.hit_ready, 1);
    chk("next_clear_sweep", reset_rbins, 1);
    chk("next_n_inrange_clr", n_inrange, 0);
    @(posedge clk); #1;
    send_hit(12'h123, 1'b1, 0);
    wait_done(fl);

    // Mid-event reset with 5 bins queued.
    tr_mode = 0;
    begin_event(0);
    wait_stream();
    for (int i = 0; i < 5; i++) send_hit($urandom_range(0, 1023), 1'b0, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mrst_enable", enable_V, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_reset_rbins", reset_rbins, 0);
    chk("mrst_evt_done", evt_done, 0);
    chk("mrst_n_inrange", n_inrange, 0);
    chk("mrst_tvalid", bus.r_bin_V_TVALID, 0);
    chk("mrst_tdata", bus.r_bin_V_TDATA, 0);
    chk("mrst_hit_ready", bus.hit_ready, 0);
    exp_q.delete();
    base = evt_cnt;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mrst_no_done", evt_cnt, base);
    tr_mode = 2;
    begin_event(12'h080);
    measure_clear();
    send_hit(12'h0A0, 1'b1, 0);
    wait_done(fl);

    // Randomized events with random backpressure.
    for (int ev = 0; ev < 6; ev++) begin
      off = $urandom_range(0, 12'h300);
      n = $urandom_range(1, 24);
      begin_event(off);
      for (int i = 0; i < n; i++)
        send_hit($urandom_range(0, 4095), i == n - 1, $urandom_range(0, 2));
      wait_done(fl);
      chk("rand_flush", fl, 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
